// File: rtl/cfu_cmd_master.sv
// cfu_cmd_master: hardware command source for a CFU.
// Upstream pushes {function_id, inputs_0, inputs_1} into a request FIFO. A
// three-state sequencer (IDLE/ISSUE/WAIT) issues one command at a time and
// pushes each response word into a response FIFO of {error, data} entries.
//
// Optional feature macro: CFU_MASTER_TIMEOUT_EN
//   Defined: a watchdog aborts a command after TIMEOUT cycles in ISSUE+WAIT and
//            pushes {error=1, data=0}.
//   Undefined: no watchdog; res_error is tied to 0.
//
// Handshake semantics (both CFU channels and both FIFO ports):
//   a transfer happens on a rising clk edge where valid && ready are both high;
//   a source holding valid keeps its payload stable until that transfer, and
//   cmd_valid/rsp_ready/payloads here are pure register decodes, never
//   combinational functions of cmd_ready or rsp_valid.
module cfu_cmd_master #(
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  // request push port
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_function_id,
  input  logic [31:0] req_inputs_0,
  input  logic [31:0] req_inputs_1,
  // response pop port
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_error,
  // CFU command channel
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  // CFU response channel
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  // status
  output logic        busy,
  output logic [15:0] done_count
);

  localparam int unsigned REQ_AW = $clog2(REQ_DEPTH);
  localparam int unsigned RES_AW = $clog2(RES_DEPTH);
  localparam int unsigned REQ_W  = 74;
  localparam int unsigned RES_W  = 33;

  localparam logic [REQ_AW:0]   REQ_FULL    = (REQ_AW+1)'(REQ_DEPTH);
  localparam logic [REQ_AW:0]   REQ_CNT_ONE = (REQ_AW+1)'(1);
  localparam logic [REQ_AW-1:0] REQ_PTR_ONE = REQ_AW'(1);
  localparam logic [RES_AW:0]   RES_FULL    = (RES_AW+1)'(RES_DEPTH);
  localparam logic [RES_AW:0]   RES_CNT_ONE = (RES_AW+1)'(1);
  localparam logic [RES_AW-1:0] RES_PTR_ONE = RES_AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // ---------------------------------------------------------------- state
  state_e            state_q;
  logic              cmd_valid_q;
  logic              rsp_ready_q;
  logic [9:0]        fid_q;
  logic [31:0]       in0_q;
  logic [31:0]       in1_q;
  logic [15:0]       done_count_q;

  // request FIFO
  logic [REQ_W-1:0]  req_mem [REQ_DEPTH];
  logic [REQ_AW-1:0] req_wr_q;
  logic [REQ_AW-1:0] req_rd_q;
  logic [REQ_AW:0]   req_cnt_q;
  logic              req_push;
  logic              req_pop;
  logic [REQ_W-1:0]  req_head;

  // response FIFO
  logic [RES_W-1:0]  res_mem [RES_DEPTH];
  logic [RES_AW-1:0] res_wr_q;
  logic [RES_AW-1:0] res_rd_q;
  logic [RES_AW:0]   res_cnt_q;
  logic              res_push;
  logic              res_pop;
  logic [RES_W-1:0]  res_push_word;
  logic [RES_W-1:0]  res_head;

  // sequencer events
  logic              start_issue;
  logic              rsp_done;
  logic              tmo_hit;

  // ---------------------------------------------------------------- request FIFO
  assign req_ready = (req_cnt_q < REQ_FULL);
  assign req_push  = req_valid && req_ready;
  assign req_head  = req_mem[req_rd_q];

  // A response slot must be free before a command leaves, so the response
  // push at the end of the command can never overflow.
  assign start_issue = (state_q == ST_IDLE) && (req_cnt_q != '0) &&
                       (res_cnt_q != RES_FULL);
  assign req_pop     = start_issue;

  // Request storage write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (req_push) begin
      req_mem[req_wr_q] <= {req_function_id, req_inputs_0, req_inputs_1};
    end
  end

  // Request FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wr_q  <= '0;
      req_rd_q  <= '0;
      req_cnt_q <= '0;
    end else begin
      if (req_push) req_wr_q <= req_wr_q + REQ_PTR_ONE;
      if (req_pop)  req_rd_q <= req_rd_q + REQ_PTR_ONE;
      case ({req_push, req_pop})
        2'b10:   req_cnt_q <= req_cnt_q + REQ_CNT_ONE;
        2'b01:   req_cnt_q <= req_cnt_q - REQ_CNT_ONE;
        default: req_cnt_q <= req_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- completion
  // A response completes the command: in ISSUE only together with acceptance,
  // in WAIT on its own. rsp_valid is ignored in IDLE.
  always_comb begin
    rsp_done = 1'b0;
    case (state_q)
      ST_ISSUE: rsp_done = cmd_ready && rsp_valid;
      ST_WAIT:  rsp_done = rsp_valid;
      default:  rsp_done = 1'b0;
    endcase
  end

`ifdef CFU_MASTER_TIMEOUT_EN
  localparam int unsigned     TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [TMO_W-1:0] tmo_q;

  // A real response in the final cycle wins over the watchdog.
  assign tmo_hit = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) &&
                   !rsp_done && (tmo_q == TMO_LAST);

  // Watchdog: cleared on entry to ISSUE, counts every ISSUE/WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (start_issue) begin
      tmo_q <= '0;
    end else if (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && !tmo_hit) begin
      tmo_q <= tmo_q + TMO_ONE;
    end
  end

  assign res_error = res_valid ? res_head[32] : 1'b0;
`else
  logic unused_cfg;

  assign tmo_hit    = 1'b0;
  assign res_error  = 1'b0;
  // TIMEOUT and the stored error bit only matter with the watchdog built in.
  assign unused_cfg = (TIMEOUT == 0) ^ res_head[32];
`endif

  // ---------------------------------------------------------------- sequencer
  // Single registered FSM: next state, cmd_valid, rsp_ready and payloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      fid_q       <= '0;
      in0_q       <= '0;
      in1_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_issue) begin
            state_q               <= ST_ISSUE;
            cmd_valid_q           <= 1'b1;
            rsp_ready_q           <= 1'b1;
            {fid_q, in0_q, in1_q} <= req_head;
          end
        end
        ST_ISSUE: begin
          if (rsp_done || tmo_hit) begin
            state_q     <= ST_IDLE;
            cmd_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
          end else if (cmd_ready) begin
            state_q     <= ST_WAIT;
            cmd_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (rsp_done || tmo_hit) begin
            state_q     <= ST_IDLE;
            rsp_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_valid_q <= 1'b0;
          rsp_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_valid               = cmd_valid_q;
  assign rsp_ready               = rsp_ready_q;
  assign cmd_payload_function_id = fid_q;
  assign cmd_payload_inputs_0    = in0_q;
  assign cmd_payload_inputs_1    = in1_q;
  assign busy                    = (state_q != ST_IDLE);

  // ---------------------------------------------------------------- response FIFO
  assign res_push      = rsp_done || tmo_hit;
  assign res_push_word = tmo_hit ? {1'b1, 32'h0} : {1'b0, rsp_payload_outputs_0};
  assign res_valid     = (res_cnt_q != '0);
  assign res_pop       = res_valid && res_ready;
  assign res_head      = res_mem[res_rd_q];
  // Gate the head so an empty FIFO presents zeros rather than stale storage.
  assign res_data      = res_valid ? res_head[31:0] : 32'h0;

  // Response storage write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (res_push) begin
      res_mem[res_wr_q] <= res_push_word;
    end
  end

  // Response FIFO pointers, occupancy and the completed-response counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_wr_q     <= '0;
      res_rd_q     <= '0;
      res_cnt_q    <= '0;
      done_count_q <= '0;
    end else begin
      if (res_push) begin
        res_wr_q     <= res_wr_q + RES_PTR_ONE;
        done_count_q <= done_count_q + 16'd1;
      end
      if (res_pop) res_rd_q <= res_rd_q + RES_PTR_ONE;
      case ({res_push, res_pop})
        2'b10:   res_cnt_q <= res_cnt_q + RES_CNT_ONE;
        2'b01:   res_cnt_q <= res_cnt_q - RES_CNT_ONE;
        default: res_cnt_q <= res_cnt_q;
      endcase
    end
  end

  assign done_count = done_count_q;

endmodule
